// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU and debug ports.
// One access in flight; fixed request-to-ack latency; saturating CPU stall counter.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  cpu_stall_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  logic [1:0]        state, state_d;
  logic              owner, owner_d;
  logic              we_q, we_d;
  logic              mis_q, mis_d;
  logic              last_gnt, last_gnt_d;
  logic              cpu_rd_sel, cpu_rd_sel_d;
  logic              dbg_rd_sel, dbg_rd_sel_d;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;
  logic              cpu_ack_d, cpu_err_d, dbg_ack_d, dbg_err_d;

  // Request selection: debug wins only when alone or when the CPU had the last grant
  logic        grant_dbg;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_mis;
  logic        unused_addr_hi;

  assign grant_dbg = dbg_req && (!cpu_req || (last_gnt == OWN_CPU));
  assign sel_we    = grant_dbg ? dbg_we    : cpu_we;
  assign sel_addr  = grant_dbg ? dbg_addr  : cpu_addr;
  assign sel_wdata = grant_dbg ? dbg_wdata : cpu_wdata;
  assign sel_mis   = (sel_addr[1:0] != 2'b00);

  // Address bits above the memory size wrap silently
  assign unused_addr_hi = ^sel_addr[31:ADDR_W+2];

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    we_d         = we_q;
    mis_d        = mis_q;
    last_gnt_d   = last_gnt;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    cpu_ack_d    = 1'b0;
    cpu_err_d    = 1'b0;
    dbg_ack_d    = 1'b0;
    dbg_err_d    = 1'b0;
    cpu_rd_sel_d = 1'b0;
    dbg_rd_sel_d = 1'b0;

    case (state)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_d     = grant_dbg ? OWN_DBG : OWN_CPU;
          we_d        = sel_we;
          mis_d       = sel_mis;
          mem_en_d    = !sel_mis;
          mem_we_d    = sel_we && !sel_mis;
          mem_addr_d  = sel_addr[ADDR_W+1:2];
          mem_wdata_d = sel_wdata;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cpu_ack_d    = (owner == OWN_CPU);
        cpu_err_d    = (owner == OWN_CPU) && mis_q;
        cpu_rd_sel_d = (owner == OWN_CPU) && !we_q && !mis_q;
        dbg_ack_d    = (owner == OWN_DBG);
        dbg_err_d    = (owner == OWN_DBG) && mis_q;
        dbg_rd_sel_d = (owner == OWN_DBG) && !we_q && !mis_q;
        last_gnt_d   = owner;
        state_d      = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      owner      <= OWN_CPU;
      we_q       <= 1'b0;
      mis_q      <= 1'b0;
      last_gnt   <= OWN_DBG;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      dbg_ack    <= 1'b0;
      dbg_err    <= 1'b0;
      cpu_rd_sel <= 1'b0;
      dbg_rd_sel <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      we_q       <= we_d;
      mis_q      <= mis_d;
      last_gnt   <= last_gnt_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      cpu_ack    <= cpu_ack_d;
      cpu_err    <= cpu_err_d;
      dbg_ack    <= dbg_ack_d;
      dbg_err    <= dbg_err_d;
      cpu_rd_sel <= cpu_rd_sel_d;
      dbg_rd_sel <= dbg_rd_sel_d;
    end
  end

  // Sync-read data arrives in the ack cycle, so it is steered by registered selects
  assign cpu_rdata = cpu_rd_sel ? mem_rdata : 32'd0;
  assign dbg_rdata = dbg_rd_sel ? mem_rdata : 32'd0;

  // Saturating count of cycles the CPU waits
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_stall_cnt <= '0;
    end else if (cpu_req && !cpu_ack && (cpu_stall_cnt != {CNT_W{1'b1}})) begin
      cpu_stall_cnt <= cpu_stall_cnt + CNT_W'(1);
    end
  end

endmodule
